pipeline_control_arbiter: RTL and testbench

Merges the pipeline control requests from the hazard sources (memory/cache miss, branch resolution, forwarding/load-use controller) into the single control word that drives every barrier stall/reset and stage stall in the LC-3b pipeline. It sits directly downstream of the forwarding controller and its sibling controllers, and directly upstream of the IF/ID, ID/EX, EX/MEM and MEM/WB barriers. It resolves simultaneous requests by OR-merging non-exclusive requests, honours exclusive requests with a sticky source lock, and optionally counts stall cycles per source.

---
 rtl/pipeline_control_arbiter_if.sv | 52 +++++
 rtl/pipeline_control_arbiter.sv | 125 ++++++++++++
 tb/tb_pipeline_control_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_arbiter_if.sv
// Pipeline control word type and the request/control bundle between hazard
// sources and pipeline_control_arbiter.
package lc3b_pipeline_pkg;

    typedef struct packed {
        logic active;
        logic exclusive;
        logic barrier_IF_ID_stall;
        logic barrier_ID_EX_stall;
        logic barrier_EX_MEM_stall;
        logic barrier_MEM_WB_stall;
        logic barrier_IF_ID_reset;
        logic barrier_ID_EX_reset;
        logic barrier_EX_MEM_reset;
        logic barrier_MEM_WB_reset;
        logic barrier_ID_EX_force_sr1_load;
        logic barrier_ID_EX_force_sr2_load;
        logic stage_IF_stall;
        logic stage_ID_stall;
        logic stage_EX_stall;
        logic stage_MEM_stall;
        logic stage_WB_stall;
    } lc3b_pipeline_control_word;

endpackage

interface pipeline_control_arbiter_if #(
    parameter int NUM_SOURCES = 3,
    parameter int PERF_WIDTH  = 16
);
    import lc3b_pipeline_pkg::*;

    localparam int IDXW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    lc3b_pipeline_control_word request [NUM_SOURCES];
    lc3b_pipeline_control_word pipeline_control;
    logic [NUM_SOURCES-1:0]    grant;
    logic                      lock_valid;
    logic [IDXW-1:0]           lock_source;
    logic [PERF_WIDTH-1:0]     stall_count [NUM_SOURCES];

    modport master (
        output request,
        input  pipeline_control, grant, lock_valid, lock_source, stall_count
    );

    modport slave (
        input  request,
        output pipeline_control, grant, lock_valid, lock_source, stall_count
    );

endinterface

// File: rtl/pipeline_control_arbiter.sv
// Merges per-source pipeline control requests into one control word with a
// sticky exclusive lock. Define PIPELINE_ARBITER_PERF_EN to build stall counters.
module pipeline_control_arbiter #(
    parameter int NUM_SOURCES = 3,
    parameter int PERF_WIDTH  = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    pipeline_control_arbiter_if.slave bus
);
    import lc3b_pipeline_pkg::*;

    localparam int IDXW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t state, state_next;
    logic [IDXW-1:0] lock_idx, lock_idx_next;

    lc3b_pipeline_control_word held_word, excl_word, merged_word, ctrl;
    logic [NUM_SOURCES-1:0] held_grant, excl_grant, merged_grant, grant;
    logic                   held, excl_found;
    logic [IDXW-1:0]        excl_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_idx_next;
        end
    end

    always_comb begin
        held         = 1'b0;
        held_word    = '0;
        held_grant   = '0;
        excl_found   = 1'b0;
        excl_idx     = '0;
        excl_word    = '0;
        excl_grant   = '0;
        merged_word  = '0;
        merged_grant = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (state == LOCKED && lock_idx == IDXW'(i) && bus.request[i].active) begin
                held          = 1'b1;
                held_word     = bus.request[i];
                held_grant[i] = 1'b1;
            end
            if (!excl_found && bus.request[i].active && bus.request[i].exclusive) begin
                excl_found    = 1'b1;
                excl_idx      = IDXW'(i);
                excl_word     = bus.request[i];
                excl_grant[i] = 1'b1;
            end
            if (bus.request[i].active) begin
                merged_word     = merged_word | bus.request[i];
                merged_grant[i] = 1'b1;
            end
        end
        merged_word.exclusive = 1'b0;

        ctrl          = '0;
        grant         = '0;
        state_next    = UNLOCKED;
        lock_idx_next = '0;
        // Reset gates the combinational outputs too, so they clear between edges.
        if (!rst_n) begin
            ctrl  = '0;
            grant = '0;
        end else if (held) begin
            ctrl          = held_word;
            grant         = held_grant;
            state_next    = LOCKED;
            lock_idx_next = lock_idx;
        end else if (excl_found) begin
            ctrl          = excl_word;
            grant         = excl_grant;
            state_next    = LOCKED;
            lock_idx_next = excl_idx;
        end else begin
            ctrl  = merged_word;
            grant = merged_grant;
        end
    end

    assign bus.pipeline_control = ctrl;
    assign bus.grant            = grant;
    assign bus.lock_valid       = (state == LOCKED);
    assign bus.lock_source      = lock_idx;

`ifdef PIPELINE_ARBITER_PERF_EN
    function automatic logic has_stall(input lc3b_pipeline_control_word w);
        return w.barrier_IF_ID_stall | w.barrier_ID_EX_stall | w.barrier_EX_MEM_stall |
               w.barrier_MEM_WB_stall | w.stage_IF_stall | w.stage_ID_stall |
               w.stage_EX_stall | w.stage_MEM_stall | w.stage_WB_stall;
    endfunction

    logic [PERF_WIDTH-1:0] cnt [NUM_SOURCES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
                if (grant[i] && has_stall(bus.request[i]) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SOURCES; i++) bus.stall_count[i] = cnt[i];
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_SOURCES; i++) bus.stall_count[i] = {PERF_WIDTH{1'b0}};
    end
`endif

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Scoreboard bench for pipeline_control_arbiter: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pipeline_control_arbiter;
    import lc3b_pipeline_pkg::*;

`ifdef PIPELINE_ARBITER_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_control_arbiter_if #(.NUM_SOURCES(3), .PERF_WIDTH(4)) bus ();

    pipeline_control_arbiter #(.NUM_SOURCES(3), .PERF_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string                     name;
        lc3b_pipeline_control_word ctrl;
        logic [2:0]                grant;
        logic                      lv;
        logic [1:0]                ls;
        bit                        chk_cnt;
        logic [3:0]                cnt [3];
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".ctrl"}, 32'(bus.pipeline_control), 32'(e.ctrl));
            chk({e.name, ".grant"}, 32'(bus.grant), 32'(e.grant));
            chk({e.name, ".lock_valid"}, 32'(bus.lock_valid), 32'(e.lv));
            chk({e.name, ".lock_source"}, 32'(bus.lock_source), 32'(e.ls));
            if (e.chk_cnt) begin
                chk({e.name, ".cnt0"}, 32'(bus.stall_count[0]), 32'(e.cnt[0]));
                chk({e.name, ".cnt1"}, 32'(bus.stall_count[1]), 32'(e.cnt[1]));
                chk({e.name, ".cnt2"}, 32'(bus.stall_count[2]), 32'(e.cnt[2]));
            end
        end
    end

    lc3b_pipeline_control_word r0, r1, r2, w;

    task automatic step(input string name, input logic rst, input lc3b_pipeline_control_word e_ctrl,
                        input logic [2:0] e_grant, input logic e_lv, input logic [1:0] e_ls,
                        input bit e_chk, input logic [3:0] c0, input logic [3:0] c1,
                        input logic [3:0] c2);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rst;
        bus.request[0] = r0;
        bus.request[1] = r1;
        bus.request[2] = r2;
        e.name    = name;
        e.ctrl    = e_ctrl;
        e.grant   = e_grant;
        e.lv      = e_lv;
        e.ls      = e_ls;
        e.chk_cnt = e_chk;
        e.cnt[0]  = c0;
        e.cnt[1]  = c1;
        e.cnt[2]  = c2;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) bus.request[i] = '0;

        // Reset with noisy inputs: everything must read zero.
        r0 = '0; r0.active = 1; r0.exclusive = 1; r0.stage_ID_stall = 1;
        r1 = '0; r1.active = 1; r1.barrier_IF_ID_reset = 1;
        r2 = '0;
        step("reset", 1'b0, '0, 3'b000, 0, 2'd0, 1, 0, 0, 0);

        // Merge of two non-exclusive sources.
        r0 = '0;
        r1 = '0; r1.active = 1; r1.barrier_ID_EX_reset = 1;
        r2 = '0; r2.active = 1; r2.barrier_IF_ID_stall = 1;
        w = '0; w.active = 1; w.barrier_ID_EX_reset = 1; w.barrier_IF_ID_stall = 1;
        step("merge", 1'b1, w, 3'b110, 0, 2'd0, 0, 0, 0, 0);

        // Exclusive priority: src0 beats src2.
        r0 = '0; r0.active = 1; r0.exclusive = 1; r0.barrier_EX_MEM_stall = 1;
        r1 = '0;
        r2 = '0; r2.active = 1; r2.exclusive = 1; r2.stage_WB_stall = 1;
        step("excl_prio", 1'b1, r0, 3'b001, 0, 2'd0, 0, 0, 0, 0);
        step("excl_locked", 1'b1, r0, 3'b001, 1, 2'd0, 0, 0, 0, 0);

        r0 = '0; r2 = '0;
        step("excl_release", 1'b1, '0, 3'b000, 1, 2'd0, 0, 0, 0, 0);

        // Lock src1, then src0 requests exclusively while src1 holds.
        r1 = '0; r1.active = 1; r1.exclusive = 1; r1.stage_EX_stall = 1;
        step("lock1", 1'b1, r1, 3'b010, 0, 2'd0, 0, 0, 0, 0);
        r0 = '0; r0.active = 1; r0.exclusive = 1; r0.barrier_MEM_WB_reset = 1;
        r1 = '0; r1.active = 1; r1.stage_EX_stall = 1; r1.stage_ID_stall = 1;
        step("hold1", 1'b1, r1, 3'b010, 1, 2'd1, 0, 0, 0, 0);
        r1 = '0;
        step("release1_grant0", 1'b1, r0, 3'b001, 1, 2'd1, 0, 0, 0, 0);
        step("relock0", 1'b1, r0, 3'b001, 1, 2'd0, 0, 0, 0, 0);

        // src0 releases while higher-index src2 goes exclusive.
        r0 = '0;
        r2 = '0; r2.active = 1; r2.exclusive = 1; r2.barrier_ID_EX_force_sr1_load = 1;
        r2.stage_MEM_stall = 1;
        step("release0_grant2", 1'b1, r2, 3'b100, 1, 2'd0, 0, 0, 0, 0);
        step("lock2", 1'b1, r2, 3'b100, 1, 2'd2, 0, 0, 0, 0);

        // Reset between edges mid-lock.
        step("reset_midlock", 1'b0, '0, 3'b000, 0, 2'd0, 0, 0, 0, 0);
        r2 = '0;
        r1 = '0; r1.active = 1; r1.barrier_EX_MEM_reset = 1; r1.barrier_ID_EX_force_sr2_load = 1;
        step("after_reset", 1'b1, r1, 3'b010, 0, 2'd0, 0, 0, 0, 0);

        // force_sr1/sr2 OR-merge across three sources.
        r0 = '0; r0.active = 1; r0.barrier_ID_EX_force_sr1_load = 1;
        r1 = '0; r1.active = 1; r1.barrier_ID_EX_force_sr2_load = 1;
        r2 = '0; r2.active = 1; r2.barrier_MEM_WB_stall = 1;
        w = '0; w.active = 1; w.barrier_ID_EX_force_sr1_load = 1;
        w.barrier_ID_EX_force_sr2_load = 1; w.barrier_MEM_WB_stall = 1;
        step("merge3", 1'b1, w, 3'b111, 0, 2'd0, 0, 0, 0, 0);

        // Counter run: fresh reset, src2 stalls, src1 granted without stall.
        r0 = '0; r1 = '0; r2 = '0;
        step("cnt_reset", 1'b0, '0, 3'b000, 0, 2'd0, 1, 0, 0, 0);
        r1 = '0; r1.active = 1; r1.barrier_ID_EX_reset = 1;
        r2 = '0; r2.active = 1; r2.stage_IF_stall = 1;
        w = '0; w.active = 1; w.barrier_ID_EX_reset = 1; w.stage_IF_stall = 1;
        for (int j = 0; j < 20; j++) begin
            logic [3:0] c2;
            c2 = PERF_EN ? ((j > 15) ? 4'd15 : 4'(j)) : 4'd0;
            step($sformatf("cnt_%0d", j), 1'b1, w, 3'b110, 0, 2'd0, 1, 0, 0, c2);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
